// File: rtl/mem_wb_stage_pkg.sv
// ============================================================================
// Module  : mem_wb_stage_pkg
// Brief   : Opcode/funct3 constants, bubble encoding and FSM states shared by
//           the mem/wb stage and its load extender.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package mem_wb_stage_pkg;

  localparam logic [31:0] NOP_ENC    = 32'h0000_0013;

  localparam logic [6:0]  OPC_LOAD   = 7'b0000011;
  localparam logic [6:0]  OPC_STORE  = 7'b0100011;
  localparam logic [6:0]  OPC_BRANCH = 7'b1100011;
  localparam logic [6:0]  OPC_JAL    = 7'b1101111;
  localparam logic [6:0]  OPC_JALR   = 7'b1100111;
  localparam logic [6:0]  OPC_CSR    = 7'b1110011;
  localparam logic [6:0]  OPC_OP     = 7'b0110011;
  localparam logic [6:0]  OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0]  OPC_LUI    = 7'b0110111;
  localparam logic [6:0]  OPC_AUIPC  = 7'b0010111;

  localparam logic [2:0]  FNC_LB     = 3'b000;
  localparam logic [2:0]  FNC_LH     = 3'b001;
  localparam logic [2:0]  FNC_LW     = 3'b010;
  localparam logic [2:0]  FNC_LBU    = 3'b100;
  localparam logic [2:0]  FNC_LHU    = 3'b101;

  localparam logic [1:0]  ST_IDLE    = 2'd0;
  localparam logic [1:0]  ST_REQ     = 2'd1;
  localparam logic [1:0]  ST_RESP    = 2'd2;

  function automatic logic writes_rd(input logic [6:0] opc);
    case (opc)
      OPC_OP, OPC_OPIMM, OPC_LUI, OPC_AUIPC,
      OPC_JAL, OPC_JALR, OPC_LOAD, OPC_CSR: return 1'b1;
      default:                              return 1'b0;
    endcase
  endfunction

  // size is funct3[1:0]: 0 byte, 1 half, 2 word
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    return ((size == 2'd1) && off[0]) || ((size == 2'd2) && (off != 2'd0));
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_wb_stage_load_extend.sv
// ============================================================================
// Module  : load_extend
// Brief   : Combinational load lane select with sign/zero extension.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module load_extend
  import mem_wb_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      i_funct3,
  input  logic [1:0]      i_offset,
  input  logic [XLEN-1:0] i_word,
  output logic [XLEN-1:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = i_word[7:0];
    case (i_offset)
      2'd0:    w_byte = i_word[7:0];
      2'd1:    w_byte = i_word[15:8];
      2'd2:    w_byte = i_word[23:16];
      default: w_byte = i_word[31:24];
    endcase
    w_half = i_offset[1] ? i_word[31:16] : i_word[15:0];
  end

  always_comb begin
    o_data = i_word;
    case (i_funct3)
      FNC_LB:  o_data = {{(XLEN-8){w_byte[7]}}, w_byte};
      FNC_LH:  o_data = {{(XLEN-16){w_half[15]}}, w_half};
      FNC_LBU: o_data = {{(XLEN-8){1'b0}}, w_byte};
      FNC_LHU: o_data = {{(XLEN-16){1'b0}}, w_half};
      FNC_LW:  o_data = i_word;
      default: o_data = i_word;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mem_wb_stage.sv
// ============================================================================
// Module  : mem_wb_stage
// Brief   : Mem/WB pipeline stage: data-cache handshake, load extension and
//           register-file writeback. Optional MEM_MISALIGN_CHECK_EN adds a
//           misaligned-access trap with sticky misalign_err.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_wb_stage
  import mem_wb_stage_pkg::*;
#(
  parameter int          XLEN     = 32,
  parameter logic [31:0] NOP_INST = NOP_ENC
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [31:0]     x_inst,
  input  logic            x_kill,
  input  logic [XLEN-1:0] x_alu_result,
  input  logic [XLEN-1:0] x_pc_plus4,
  input  logic [XLEN-1:0] x_csr_rdata,
  input  logic [XLEN-1:0] x_store_data,
  input  logic [3:0]      x_mem_wmask,
  input  logic            x_mem_re,
  output logic            cpu_req_valid,
  input  logic            cpu_req_ready,
  output logic [XLEN-3:0] cpu_req_addr,
  output logic [XLEN-1:0] cpu_req_data,
  output logic [3:0]      cpu_req_write,
  input  logic            cpu_resp_valid,
  input  logic [XLEN-1:0] cpu_resp_data,
  output logic            stall,
  output logic            wb_we,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic [31:0]     mem_wb_inst,
  output logic [31:0]     prev_prev_inst
`ifdef MEM_MISALIGN_CHECK_EN
  ,
  output logic            misalign_err
`endif
);

  logic [1:0]      r_state, w_next_state;
  logic [31:0]     r_inst, r_prev;
  logic [XLEN-1:0] r_alu, r_pc4, r_csr, r_sdata;
  logic [3:0]      r_wmask;
  logic            r_re, r_fresh;

  logic            w_stall, w_cap, w_cap_re, w_cap_mem, w_cap_bad, w_cap_go;
  logic [3:0]      w_cap_wmask;
  logic [6:0]      w_opc;
  logic [XLEN-1:0] w_load_data;

  assign w_stall     = (r_state == ST_REQ) || ((r_state == ST_RESP) && !cpu_resp_valid);
  assign w_cap       = !w_stall;
  assign w_cap_wmask = x_kill ? 4'h0 : x_mem_wmask;
  assign w_cap_re    = !x_kill && x_mem_re;
  assign w_cap_mem   = w_cap_re || (w_cap_wmask != 4'h0);
  assign w_cap_go    = w_cap_mem && !w_cap_bad;

`ifdef MEM_MISALIGN_CHECK_EN
  logic r_misalign;

  assign w_cap_bad    = w_cap_mem && is_misaligned(x_inst[13:12], x_alu_result[1:0]);
  assign misalign_err = r_misalign;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_misalign <= 1'b0;
    else if (w_cap && w_cap_bad)
      r_misalign <= 1'b1;
  end
`else
  assign w_cap_bad = 1'b0;
`endif

  // Stage registers advance only when the cache is not holding the pipe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_inst  <= NOP_INST;
      r_prev  <= NOP_INST;
      r_alu   <= '0;
      r_pc4   <= '0;
      r_csr   <= '0;
      r_sdata <= '0;
      r_wmask <= 4'h0;
      r_re    <= 1'b0;
      r_fresh <= 1'b0;
    end else begin
      r_fresh <= w_cap;
      if (w_cap) begin
        r_prev  <= r_inst;
        r_inst  <= x_kill ? NOP_INST : x_inst;
        r_alu   <= x_alu_result;
        r_pc4   <= x_pc_plus4;
        r_csr   <= x_csr_rdata;
        r_sdata <= x_store_data;
        r_wmask <= w_cap_wmask;
        r_re    <= w_cap_re;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_state <= ST_IDLE;
    else
      r_state <= w_next_state;
  end

  // RESP with a response releases the stall, so a following memory op is
  // captured on that same edge and goes straight to REQ.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: if (w_cap_go)       w_next_state = ST_REQ;
      ST_REQ:  if (cpu_req_ready)  w_next_state = r_re ? ST_RESP : ST_IDLE;
      ST_RESP: if (cpu_resp_valid) w_next_state = w_cap_go ? ST_REQ : ST_IDLE;
      default:                     w_next_state = ST_IDLE;
    endcase
  end

  assign w_opc = r_inst[6:0];

  always_comb begin
    cpu_req_valid = (r_state == ST_REQ);
    stall         = w_stall;
    wb_we         = 1'b0;
    if (writes_rd(w_opc) && (r_inst[11:7] != 5'd0)) begin
      if (w_opc == OPC_LOAD)
        wb_we = (r_state == ST_RESP) && cpu_resp_valid;
      else
        wb_we = r_fresh;
    end
  end

  load_extend #(.XLEN(XLEN)) u_load_extend (
    .i_funct3 (r_inst[14:12]),
    .i_offset (r_alu[1:0]),
    .i_word   (cpu_resp_data),
    .o_data   (w_load_data)
  );

  always_comb begin
    wb_data = r_alu;
    case (w_opc)
      OPC_LOAD:          wb_data = w_load_data;
      OPC_JAL, OPC_JALR: wb_data = r_pc4;
      OPC_CSR:           wb_data = r_csr;
      default:           wb_data = r_alu;
    endcase
  end

  assign cpu_req_addr   = r_alu[XLEN-1:2];
  assign cpu_req_data   = r_sdata;
  assign cpu_req_write  = r_wmask;
  assign wb_rd          = r_inst[11:7];
  assign mem_wb_inst    = r_inst;
  assign prev_prev_inst = r_prev;

endmodule

`default_nettype wire

// File: tb/tb_mem_wb_stage.sv
// ============================================================================
// Module  : tb_mem_wb_stage
// Brief   : Self-checking bench for mem_wb_stage: directed scenarios plus a
//           randomized run against a transaction-level reference model.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mem_wb_stage;

  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam logic [6:0]  P_LD  = 7'b0000011;
  localparam logic [6:0]  P_ST  = 7'b0100011;
  localparam logic [6:0]  P_OP  = 7'b0110011;
  localparam logic [6:0]  P_JAL = 7'b1101111;
  localparam logic [6:0]  P_JR  = 7'b1100111;
  localparam logic [6:0]  P_CSR = 7'b1110011;
  localparam logic [6:0]  P_BR  = 7'b1100011;
  localparam int          N_RND = 300;

  typedef struct packed {
    logic        ld;
    logic [4:0]  rd;
    logic [31:0] val;
    logic [2:0]  f3;
    logic [1:0]  off;
  } wb_t;

  typedef struct packed {
    logic [29:0] addr;
    logic [31:0] data;
    logic [3:0]  wr;
  } req_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] x_inst, x_alu_result, x_pc_plus4, x_csr_rdata, x_store_data;
  logic        x_kill, x_mem_re;
  logic [3:0]  x_mem_wmask;
  logic        cpu_req_valid, cpu_req_ready;
  logic [29:0] cpu_req_addr;
  logic [31:0] cpu_req_data;
  logic [3:0]  cpu_req_write;
  logic        cpu_resp_valid;
  logic [31:0] cpu_resp_data;
  logic        stall, wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data, mem_wb_inst, prev_prev_inst;
`ifdef MEM_MISALIGN_CHECK_EN
  logic        misalign_err;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_wb_stage dut (
    .clk            (clk),
    .reset          (reset),
    .x_inst         (x_inst),
    .x_kill         (x_kill),
    .x_alu_result   (x_alu_result),
    .x_pc_plus4     (x_pc_plus4),
    .x_csr_rdata    (x_csr_rdata),
    .x_store_data   (x_store_data),
    .x_mem_wmask    (x_mem_wmask),
    .x_mem_re       (x_mem_re),
    .cpu_req_valid  (cpu_req_valid),
    .cpu_req_ready  (cpu_req_ready),
    .cpu_req_addr   (cpu_req_addr),
    .cpu_req_data   (cpu_req_data),
    .cpu_req_write  (cpu_req_write),
    .cpu_resp_valid (cpu_resp_valid),
    .cpu_resp_data  (cpu_resp_data),
    .stall          (stall),
    .wb_we          (wb_we),
    .wb_rd          (wb_rd),
    .wb_data        (wb_data),
    .mem_wb_inst    (mem_wb_inst),
    .prev_prev_inst (prev_prev_inst)
`ifdef MEM_MISALIGN_CHECK_EN
    ,
    .misalign_err   (misalign_err)
`endif
  );

  function automatic logic [31:0] enc(input logic [6:0] opc, input logic [2:0] f3, input logic [4:0] rd);
    return {17'd0, f3, rd, opc};
  endfunction

  // Reference load result: shift the addressed lane down, then extend.
  function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [2:0] f3, input logic [1:0] off);
    logic [31:0] sh;
    sh = w >> (8 * off);
    case (f3)
      3'd0:    return {{24{sh[7]}}, sh[7:0]};
      3'd1:    return {{16{sh[15]}}, sh[15:0]};
      3'd4:    return {24'd0, sh[7:0]};
      3'd5:    return {16'd0, sh[15:0]};
      default: return w;
    endcase
  endfunction

  task automatic drive(input logic [31:0] inst, input logic [31:0] alu, input logic [31:0] pc4,
                       input logic [31:0] csr, input logic [31:0] sd, input logic [3:0] wm,
                       input logic re, input logic kill);
    x_inst = inst; x_alu_result = alu; x_pc_plus4 = pc4; x_csr_rdata = csr;
    x_store_data = sd; x_mem_wmask = wm; x_mem_re = re; x_kill = kill;
  endtask

  task automatic nop_in;
    drive(NOP, 32'd0, 32'd0, 32'd0, 32'd0, 4'h0, 1'b0, 1'b0);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    nop_in();
    cpu_req_ready = 1'b0; cpu_resp_valid = 1'b0; cpu_resp_data = 32'd0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({mem_wb_inst, prev_prev_inst} !== {NOP, NOP}) begin
      errors++;
      $display("FAIL reset_insts got %h/%h want %h/%h", mem_wb_inst, prev_prev_inst, NOP, NOP);
    end
    checks++;
    if ({cpu_req_valid, stall, wb_we, wb_data} !== {1'b0, 1'b0, 1'b0, 32'd0}) begin
      errors++;
      $display("FAIL reset_ctrl got valid=%b stall=%b we=%b data=%h want 0/0/0/0",
               cpu_req_valid, stall, wb_we, wb_data);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_alu;
    drive(enc(P_OP, 3'd0, 5'd5), 32'h0000_00AA, 32'd0, 32'd0, 32'd0, 4'h0, 1'b0, 1'b0);
    @(negedge clk);
    nop_in();
    #1;
    checks++;
    if ({wb_we, wb_rd, wb_data, stall, cpu_req_valid} !== {1'b1, 5'd5, 32'hAA, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL alu_wb got we=%b rd=%0d data=%h stall=%b valid=%b want 1/5/000000aa/0/0",
               wb_we, wb_rd, wb_data, stall, cpu_req_valid);
    end
    @(negedge clk);
    #1;
    checks++;
    if (wb_we !== 1'b0) begin
      errors++;
      $display("FAIL alu_single_pulse got we=%b want 0", wb_we);
    end
  endtask

  task automatic test_load_byte;
    int stalls = 0;
    int pulses = 0;
    drive(enc(P_LD, 3'd0, 5'd6), 32'h0000_1003, 32'd0, 32'd0, 32'd0, 4'h0, 1'b1, 1'b0);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      nop_in();
      cpu_req_ready  = (c == 1);
      cpu_resp_valid = (c == 4);
      cpu_resp_data  = (c == 4) ? 32'h8000_0000 : 32'h0;
      #1;
      if (stall) stalls++;
      if (c == 1) begin
        checks++;
        if ({cpu_req_valid, cpu_req_addr, cpu_req_write} !== {1'b1, 30'h400, 4'h0}) begin
          errors++;
          $display("FAIL lb_req got valid=%b addr=%h wr=%h want 1/00000400/0",
                   cpu_req_valid, cpu_req_addr, cpu_req_write);
        end
      end
      if (wb_we) begin
        pulses++;
        checks++;
        if ({wb_rd, wb_data} !== {5'd6, 32'hFFFF_FF80}) begin
          errors++;
          $display("FAIL lb_data got rd=%0d data=%h want rd=6 data=ffffff80", wb_rd, wb_data);
        end
      end
    end
    checks++;
    if (stalls != 3) begin
      errors++;
      $display("FAIL lb_stall_cycles got %0d want 3", stalls);
    end
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("FAIL lb_wb_pulses got %0d want 1", pulses);
    end
  endtask

  task automatic test_store;
    int stalls = 0;
    int wbs = 0;
    drive(enc(P_ST, 3'd2, 5'd0), 32'h0000_2000, 32'd0, 32'd0, 32'hDEAD_BEEF, 4'hF, 1'b0, 1'b0);
    cpu_req_ready = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      nop_in();
      cpu_req_ready = (c == 5);
      #1;
      if (stall) stalls++;
      if (wb_we) wbs++;
      if (cpu_req_valid) begin
        checks++;
        if ({cpu_req_addr, cpu_req_data, cpu_req_write} !== {30'h800, 32'hDEAD_BEEF, 4'hF}) begin
          errors++;
          $display("FAIL sw_req_stable cycle %0d got addr=%h data=%h wr=%h want 00000800/deadbeef/f",
                   c, cpu_req_addr, cpu_req_data, cpu_req_write);
        end
      end
    end
    cpu_req_ready = 1'b0;
    checks++;
    if (stalls != 5) begin
      errors++;
      $display("FAIL sw_stall_cycles got %0d want 5", stalls);
    end
    checks++;
    if (wbs != 0) begin
      errors++;
      $display("FAIL sw_no_wb got %0d pulses want 0", wbs);
    end
  endtask

  task automatic test_lhu_add;
    logic [31:0] lhu, add;
    int p7 = 0;
    int p8 = 0;
    lhu = enc(P_LD, 3'd5, 5'd7);
    add = enc(P_OP, 3'd0, 5'd8);
    drive(lhu, 32'h0000_1002, 32'd0, 32'd0, 32'd0, 4'h0, 1'b1, 1'b0);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (c <= 2) drive(add, 32'h55, 32'd0, 32'd0, 32'd0, 4'h0, 1'b0, 1'b0);
      else nop_in();
      cpu_req_ready  = (c == 1);
      cpu_resp_valid = (c == 2);
      cpu_resp_data  = (c == 2) ? 32'h8000_1234 : 32'h0;
      #1;
      if (wb_we && wb_rd == 5'd7) begin
        p7++;
        checks++;
        if (wb_data !== 32'h0000_8000) begin
          errors++;
          $display("FAIL lhu_data got %h want 00008000", wb_data);
        end
      end
      if (wb_we && wb_rd == 5'd8) begin
        p8++;
        checks++;
        if (wb_data !== 32'h55) begin
          errors++;
          $display("FAIL add_after_load_data got %h want 00000055", wb_data);
        end
      end
      if (c == 3) begin
        checks++;
        if ({mem_wb_inst, prev_prev_inst} !== {add, lhu}) begin
          errors++;
          $display("FAIL prev_prev got %h/%h want %h/%h", mem_wb_inst, prev_prev_inst, add, lhu);
        end
      end
    end
    checks++;
    if ({p7, p8} != {32'd1, 32'd1}) begin
      errors++;
      $display("FAIL lhu_add_pulses got %0d/%0d want 1/1", p7, p8);
    end
  endtask

  task automatic test_kill;
    drive(enc(P_LD, 3'd2, 5'd9), 32'h0000_3000, 32'd0, 32'd0, 32'd0, 4'h0, 1'b1, 1'b1);
    cpu_req_ready = 1'b1;
    @(negedge clk);
    nop_in();
    #1;
    checks++;
    if ({mem_wb_inst, cpu_req_valid, stall, wb_we} !== {NOP, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL kill got inst=%h valid=%b stall=%b we=%b want %h/0/0/0",
               mem_wb_inst, cpu_req_valid, stall, wb_we, NOP);
    end
    @(negedge clk);
    #1;
    checks++;
    if ({cpu_req_valid, wb_we} !== 2'b00) begin
      errors++;
      $display("FAIL kill_after got valid=%b we=%b want 0/0", cpu_req_valid, wb_we);
    end
    cpu_req_ready = 1'b0;
  endtask

  task automatic test_reset_mid_req;
    int wbs = 0;
    drive(enc(P_LD, 3'd2, 5'd10), 32'h0000_4000, 32'd0, 32'd0, 32'd0, 4'h0, 1'b1, 1'b0);
    cpu_req_ready = 1'b0;
    @(negedge clk);
    nop_in();
    #1;
    checks++;
    if ({cpu_req_valid, stall} !== 2'b11) begin
      errors++;
      $display("FAIL rst_mid_pre got valid=%b stall=%b want 1/1", cpu_req_valid, stall);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({cpu_req_valid, stall} !== 2'b00) begin
      errors++;
      $display("FAIL rst_mid_async got valid=%b stall=%b want 0/0", cpu_req_valid, stall);
    end
    @(negedge clk);
    reset = 1'b0;
    cpu_resp_valid = 1'b1;
    cpu_resp_data  = 32'h1234_5678;
    for (int c = 0; c < 4; c++) begin
      if (c > 0) begin
        @(negedge clk);
        cpu_resp_valid = 1'b0;
      end
      #1;
      if (wb_we) wbs++;
    end
    checks++;
    if (wbs != 0) begin
      errors++;
      $display("FAIL rst_mid_no_wb got %0d pulses want 0", wbs);
    end
  endtask

  task automatic gen_instr(output logic [31:0] ci, output logic [31:0] ca, output logic [31:0] cp,
                           output logic [31:0] cc, output logic [31:0] cs, output logic [3:0] cw,
                           output logic cr, output logic ck);
    logic [2:0] lf [5];
    logic [2:0] f3;
    logic [4:0] rd;
    int         k;
    lf[0] = 3'd0; lf[1] = 3'd1; lf[2] = 3'd2; lf[3] = 3'd4; lf[4] = 3'd5;
    k  = int'($urandom_range(0, 6));
    rd = 5'($urandom_range(0, 31));
    ca = $urandom; cp = $urandom; cc = $urandom; cs = $urandom;
    cw = 4'h0; cr = 1'b0; f3 = 3'd0;
    case (k)
      0: ci = enc(P_OP, 3'd0, rd);
      1: ci = enc(P_JAL, 3'd0, rd);
      2: ci = enc(P_JR, 3'd0, rd);
      3: ci = enc(P_CSR, 3'($urandom_range(1, 3)), rd);
      4: begin f3 = lf[$urandom_range(0, 4)]; cr = 1'b1; ci = enc(P_LD, f3, rd); end
      5: begin f3 = 3'($urandom_range(0, 2)); cw = 4'($urandom_range(1, 15)); ci = enc(P_ST, f3, rd); end
      default: ci = enc(P_BR, 3'd0, rd);
    endcase
    if (f3[1:0] == 2'd1) ca[0] = 1'b0;
    if (f3[1:0] == 2'd2) ca[1:0] = 2'b00;
    ck = ($urandom_range(0, 9) == 0);
  endtask

  task automatic test_random;
    wb_t         wbq[$];
    req_t        rq[$];
    wb_t         e;
    req_t        q;
    logic [31:0] expv, h0, h1;
    logic [31:0] ci, ca, cp, cc, cs;
    logic [3:0]  cw;
    logic        cr, ck, pend;
    logic [6:0]  opc;
    logic [4:0]  rd;
    int          issued, cyc, dly;
    issued = 0; cyc = 0; dly = 0; pend = 1'b0; h0 = NOP; h1 = NOP;
    reset = 1'b1;
    nop_in();
    cpu_req_ready = 1'b0; cpu_resp_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    gen_instr(ci, ca, cp, cc, cs, cw, cr, ck);
    while ((issued < N_RND || wbq.size() != 0 || rq.size() != 0 || pend) && cyc < 6000) begin
      @(negedge clk);
      cyc++;
      cpu_req_ready = ($urandom_range(0, 2) != 0);
      if (pend && dly == 0) begin
        cpu_resp_valid = 1'b1;
        pend = 1'b0;
      end else begin
        if (pend) dly--;
        // Stray responses while no load is outstanding must be ignored.
        cpu_resp_valid = !pend && ($urandom_range(0, 7) == 0);
      end
      cpu_resp_data = $urandom;
      if (issued < N_RND) drive(ci, ca, cp, cc, cs, cw, cr, ck);
      else nop_in();
      #1;
      checks++;
      if ({mem_wb_inst, prev_prev_inst} !== {h0, h1}) begin
        errors++;
        $display("FAIL rnd_pipe cyc %0d got %h/%h want %h/%h", cyc, mem_wb_inst, prev_prev_inst, h0, h1);
      end
      if (wb_we) begin
        checks++;
        if (wbq.size() == 0) begin
          errors++;
          $display("FAIL rnd_wb_unexpected cyc %0d got rd=%0d data=%h want no write", cyc, wb_rd, wb_data);
        end else begin
          e = wbq.pop_front();
          expv = e.ld ? ref_load(cpu_resp_data, e.f3, e.off) : e.val;
          if ({wb_rd, wb_data, (!e.ld || cpu_resp_valid)} !== {e.rd, expv, 1'b1}) begin
            errors++;
            $display("FAIL rnd_wb cyc %0d got rd=%0d data=%h resp=%b want rd=%0d data=%h",
                     cyc, wb_rd, wb_data, cpu_resp_valid, e.rd, expv);
          end
        end
      end
      if (cpu_req_valid && cpu_req_ready) begin
        checks++;
        if (rq.size() == 0) begin
          errors++;
          $display("FAIL rnd_req_unexpected cyc %0d got addr=%h wr=%h want no request", cyc, cpu_req_addr, cpu_req_write);
        end else begin
          q = rq.pop_front();
          if ({cpu_req_addr, cpu_req_write} !== {q.addr, q.wr} ||
              (q.wr != 4'h0 && cpu_req_data !== q.data)) begin
            errors++;
            $display("FAIL rnd_req cyc %0d got addr=%h data=%h wr=%h want addr=%h data=%h wr=%h",
                     cyc, cpu_req_addr, cpu_req_data, cpu_req_write, q.addr, q.data, q.wr);
          end
          if (q.wr == 4'h0) begin
            pend = 1'b1;
            dly = int'($urandom_range(0, 3));
          end
        end
      end
      if (!stall) begin
        h1 = h0;
        h0 = (issued < N_RND && !ck) ? ci : NOP;
        if (issued < N_RND) begin
          opc = ci[6:0];
          rd  = ci[11:7];
          if (!ck) begin
            if (cr) begin
              rq.push_back('{ca[31:2], cs, 4'h0});
              if (rd != 5'd0) wbq.push_back('{1'b1, rd, 32'd0, ci[14:12], ca[1:0]});
            end else if (cw != 4'h0) begin
              rq.push_back('{ca[31:2], cs, cw});
            end else if (rd != 5'd0 && opc != P_BR) begin
              expv = (opc == P_JAL || opc == P_JR) ? cp : (opc == P_CSR) ? cc : ca;
              wbq.push_back('{1'b0, rd, expv, 3'd0, 2'd0});
            end
          end
          issued++;
          if (issued < N_RND) gen_instr(ci, ca, cp, cc, cs, cw, cr, ck);
        end
      end
    end
    cpu_resp_valid = 1'b0;
    cpu_req_ready  = 1'b0;
    checks++;
    if (issued != N_RND || wbq.size() != 0 || rq.size() != 0 || pend) begin
      errors++;
      $display("FAIL rnd_drain got issued=%0d wbq=%0d rq=%0d pend=%b want %0d/0/0/0",
               issued, wbq.size(), rq.size(), pend, N_RND);
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load_byte();
    test_store();
    test_lhu_add();
    test_kill();
    test_reset_mid_req();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout got no finish want finish before 1000000");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- Final pipeline stage, directly downstream of the execute-stage control/datapath.
- Registers the execute-stage results and runs the data-cache request/response handshake for loads and stores.
- Aligns and sign/zero-extends load data, selects the writeback value, and drives the register-file write port.
- Supplies the mem/wb instruction and the previous-previous instruction to the execute stage for forwarding, and stalls the front of the pipeline while a cache access is outstanding.

Parameters:
- XLEN, 32, datapath and address width.
- NOP_INST, 32'h0000_0013, bubble encoding (addi x0,x0,0).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- x_inst  in  32  instruction leaving execute
- x_kill  in  1  replace captured instruction with NOP_INST
- x_alu_result  in  32  ALU result (byte address for load/store)
- x_pc_plus4  in  32  link value for jal/jalr
- x_csr_rdata  in  32  CSR read value
- x_store_data  in  32  lane-positioned store data
- x_mem_wmask  in  4  byte write enables
- x_mem_re  in  1  load request
- cpu_req_valid  out  1  cache request valid
- cpu_req_ready  in  1  cache accepts request
- cpu_req_addr  out  30  word address, {alu[31:2]}
- cpu_req_data  out  32  store data
- cpu_req_write  out  4  byte mask (0 = read)
- cpu_resp_valid  in  1  load data valid
- cpu_resp_data  in  32  load word
- stall  out  1  freeze fetch/decode/execute registers
- wb_we  out  1  register-file write enable
- wb_rd  out  5  destination register
- wb_data  out  32  writeback value
- mem_wb_inst  out  32  instruction in this stage
- prev_prev_inst  out  32  instruction retired one slot earlier

Behaviour:
- Reset (async):
  - mem_wb_inst and prev_prev_inst = NOP_INST.
  - All data registers = 0.
  - State = IDLE.
  - cpu_req_valid, stall and wb_we = 0.
- Capture: on a clk edge with stall=0:
  - prev_prev_inst <= mem_wb_inst.
  - mem_wb_inst <= x_kill ? NOP_INST : x_inst.
  - Operands, wmask and re are latched; wmask/re are forced to 0 on x_kill.
  - When stall=1, all stage registers hold.
- FSM states: IDLE, REQ, RESP.
  - IDLE -> REQ at capture when the captured re=1 or wmask!=0.
  - REQ: cpu_req_valid=1 with addr/data/write held stable until cpu_req_ready.
    - Handshake is cpu_req_valid && cpu_req_ready in the same cycle.
    - On handshake: store -> IDLE; load -> RESP.
  - RESP: wait for cpu_resp_valid, then -> IDLE.
  - cpu_resp_valid outside RESP is ignored.
- stall = (state==REQ) || (state==RESP && !cpu_resp_valid). This is combinational, so execute advances in the cycle the response arrives.
- Load extraction from cpu_resp_data using alu[1:0] and funct3:
  - LB/LBU select byte lane alu[1:0].
  - LH/LHU select half-word lane alu[1].
  - LW takes the full word.
  - Sign- or zero-extend to 32 bits.
- Writeback select by opcode:
  - LOAD -> extracted data.
  - JAL/JALR -> pc_plus4.
  - CSR -> csr_rdata.
  - otherwise -> alu_result.
- wb_rd = mem_wb_inst[11:7].
- wb_we = 1 when the opcode writes rd and rd!=0, qualified as follows:
  - Non-load instructions: asserted for exactly the one cycle following capture.
  - Loads: asserted only in the RESP cycle with cpu_resp_valid=1.
  - Stores, branches and NOP: always 0.
- Reset mid-access drops cpu_req_valid immediately; any in-flight response is discarded.
- Back-to-back memory ops: the second is captured on the edge where stall falls, and its REQ starts the next cycle. No request is lost or duplicated.

Optional Feature:
- MEM_MISALIGN_CHECK_EN defined:
  - Faulting cases: a load/store with a half access where alu[0]=1, or a word access where alu[1:0]!=0.
  - Such an access issues no cache request and no writeback.
  - It sets the sticky output misalign_err (1 bit), which is cleared only by reset.
- Undefined: no check and no misalign_err port. Low address bits are dropped by word addressing, and the lane is chosen from alu[1:0] as above.

Decomposition:
- Shared package/header holds:
  - Opcode and funct3 constants (OPC_LOAD, OPC_STORE, OPC_JAL, OPC_JALR, OPC_CSR, FNC_LB..FNC_LHU).
  - NOP encoding.
  - FSM state encodings.
- One sub-module, load_extend: purely combinational lane select plus sign/zero extension.

Test Plan:
- ALU op: add x5 with alu=0x0000_00AA, cache idle -> next cycle wb_we=1, wb_rd=5, wb_data=0xAA, stall=0, no cpu_req_valid.
- LB at alu=0x1003, resp_data=0x8000_0000, ready on first REQ cycle, resp_valid 2 cycles later -> stall=1 for 3 cycles, wb_data=0xFFFF_FF80, single wb_we pulse.
- SW at 0x2000, data 0xDEAD_BEEF, cpu_req_ready held low 4 cycles -> addr=0x800, write=4'hF, data stable throughout, stall=1 for 5 cycles, wb_we never asserted.
- LHU at 0x1002 followed by add -> wb_data=0x0000_8000 from resp 0x8000_1234; add writes back exactly once after the stall releases; prev_prev_inst shows the LHU after the add retires.
- x_kill with a load presented -> mem_wb_inst=0x0000_0013, no cache request, wb_we=0.
- Reset asserted while in REQ -> cpu_req_valid=0 and stall=0 asynchronously; a later resp_valid pulse produces no writeback.
